pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised chain of pipeline registers for the core datapath. Each slot carries a valid bit and a register-writeback record (enable, address, data). It supports per-stage stall with bubble insertion, per-stage flush, and an optional youngest-first forwarding lookup over all in-flight records. It replaces the fixed, stall-less inter-stage registers between decode and writeback, and feeds the register file write port from its last stage.

## Interface
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width
- STAGES, 4, number of register slots (≥2); slot 0 youngest, slot STAGES-1 oldest
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- in_valid  in  1  new record offered to slot 0
- in_ready  out  1  slot 0 accepts this cycle
- in_wen  in  1  record writes a register
- in_waddr  in  ADDR_W  destination register
- in_wdata  in  DATA_W  writeback data
- stall  in  STAGES  stall[k]: slot k must not advance
- flush  in  STAGES  flush[k]: kill slots 0..k
- out_valid  out  1  slot STAGES-1 valid
- out_wen  out  1  out_valid & slot wen (to regfile w_en)
- out_waddr  out  ADDR_W  slot STAGES-1 address
- out_wdata  out  DATA_W  slot STAGES-1 data
- rd_addr_a, rd_addr_b  in  ADDR_W  forwarding lookup addresses
- rf_data_a, rf_data_b  in  DATA_W  register file read data
- fwd_data_a, fwd_data_b  out  DATA_W  resolved operand
- fwd_hit_a, fwd_hit_b  out  1  operand came from a slot

## Operation
- hold[j] = OR of stall[k] for k ≥ j. A slot with hold set keeps its contents.
- Slot k+1 with hold[k+1]=0 loads slot k when hold[k]=0. When hold[k]=1 it loads a bubble (valid=0).
- Slot 0 with hold[0]=0 loads the input record, with valid = in_valid & in_ready.
- in_ready = ~hold[0] & ~(|flush).
- Flush beats stall. If flush[k] is set, slots 0..k have valid=0 next cycle regardless of stall. Slots above k follow the normal rules.
- A set flush means the slot at k+1 loads a bubble, because its source (slot k) is being killed.
- Multiple flush bits act as the highest set index.
- Payload of invalid slots is don't-care. wen is never visible through out_wen while invalid.
- Forwarding:
  - A slot matches when valid & wen & waddr==rd_addr & rd_addr≠0.
  - The lowest-index (youngest) match wins; fwd_data is that slot's wdata and fwd_hit=1.
  - With no match, fwd_data=rf_data and fwd_hit=0.
  - Address 0 never hits.
  - The lookup is purely combinational.

## Timing
- Reset (async assert): all slot valid=0 and all payloads 0. Therefore out_valid=0, out_wen=0, out_waddr=0, out_wdata=0, in_ready=1 (given stall=flush=0), fwd_hit=0.
- Latency: a record accepted at edge n appears at the output after edge n+STAGES-1 (STAGES cycles of residency), given no stall.
- Throughput: one record per cycle with no stall.
- Each stall cycle on slot k adds one bubble after slot k.
- stall and flush are sampled at the rising edge. Their effects are visible in the next cycle.
- in_ready is combinational from stall and flush. No combinational path exists from in_valid to in_ready.
- Reset mid-stream discards all records immediately. Nothing reaches the regfile afterwards.

## Configuration
- PIPE_FWD_EN defined: forwarding comparators and muxes are built as above.
- PIPE_FWD_EN undefined: fwd_data_x = rf_data_x and fwd_hit_x = 0. No comparators are synthesised. The ports remain present.

## Structure
- Shared package pipe_pkg holds:
  - default DATA_W / ADDR_W constants;
  - typedef wb_rec_t {valid, wen, waddr, wdata};
  - the zero-register constant REG_ZERO.
- Sub-module pipe_slot: one register slot with inputs hold, bubble and kill, and async reset. It is instantiated STAGES times with a generate loop.
- The forwarding priority mux lives in the top module under PIPE_FWD_EN.

## Test plan
- Stream 4 records (waddr 1..4, wdata 0x11,0x22,0x33,0x44, wen=1), STAGES=4 → out_wen=1 on 4 consecutive cycles, starting 3 edges after the first accept, data in order.
- Fill the chain, then stall[1]=1 for 2 cycles → slots 0,1 frozen and in_ready=0; two out_valid=0 gaps appear, then the held records emerge with no loss or duplication.
- Same cycle: flush[2]=1 and stall[0]=1 with all slots valid → next cycle slots 0..2 invalid and slot 3 holds the former slot 2 record being killed? No: slot 3 loads a bubble, and the former slot 3 record exits on out_*.
- Slot 1 {waddr 5, 0xAAAA}, slot 3 {waddr 5, 0xBBBB}, rd_addr_a=5 → fwd_data_a=0xAAAA, hit=1. With rd_addr_b=0 and rf_data_b=0x1234 → 0x1234, hit=0. With PIPE_FWD_EN undefined → rf data, hit=0.
- Invalid slot with wen=1, waddr 7 → no forward hit and out_wen=0.
- Assert rst asynchronously mid-stream between edges → out_valid/out_wen drop to 0 immediately. After release, the first new record emerges STAGES cycles after accept.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the pipeline register chain
//
// Purpose : default datapath widths, the writeback record layout and the
//           hard-wired zero register address used by the forwarding lookup.
// Ports   : none (package).
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_ADDR_W = 5;

  // Register 0 reads as zero, so it must never be forwarded.
  localparam logic [PIPE_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                   valid;
    logic                   wen;
    logic [PIPE_ADDR_W-1:0] waddr;
    logic [PIPE_DATA_W-1:0] wdata;
  } wb_rec_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one register slot of the pipeline chain
//
// Purpose : holds one writeback record (valid, wen, waddr, wdata).
// Ports   : clk, rst         clock, async active-high reset
//           i_hold           keep current contents
//           i_bubble         load an invalid record instead of the source
//           i_kill           force valid=0 next cycle (wins over i_hold)
//           i_valid/i_wen/i_waddr/i_wdata   source record
//           o_valid/o_wen/o_waddr/o_wdata   stored record
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int ADDR_W = PIPE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic              i_kill,
  input  logic              i_valid,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_valid,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata
);

  logic              r_valid;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if (i_kill) begin
        r_valid <= 1'b0;
      end else if (!i_hold) begin
        r_valid <= i_valid & ~i_bubble;
      end
      // Payload of an invalid slot is don't-care, so it simply follows the
      // source whenever the slot is not held.
      if (!i_hold) begin
        r_wen   <= i_wen;
        r_waddr <= i_waddr;
        r_wdata <= i_wdata;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_wen   = r_wen;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - stallable/flushable writeback pipeline with forwarding
//
// Purpose : STAGES-deep chain of writeback records between decode and the
//           register file write port. Slot 0 is youngest, slot STAGES-1 oldest
//           and drives out_*. Optional youngest-first forwarding lookup is
//           built only when the macro PIPE_FWD_EN is defined; otherwise the
//           fwd_* outputs pass the register file data straight through.
// Ports   : clk, rst                 clock, async active-high reset
//           in_valid/in_ready        input handshake into slot 0
//           in_wen/in_waddr/in_wdata input record
//           stall[k], flush[k]       per-slot stall / kill slots 0..k
//           out_valid/out_wen/out_waddr/out_wdata   oldest slot (regfile write)
//           rd_addr_x, rf_data_x     forwarding lookup address / regfile data
//           fwd_data_x, fwd_hit_x    resolved operand / came from a slot
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [STAGES-1:0] stall,
  input  logic [STAGES-1:0] flush,
  output logic              out_valid,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0] out_wdata,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic [DATA_W-1:0] fwd_data_b,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b
);

  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_kill;
  logic              w_in_ready;

  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_wen;
  logic [ADDR_W-1:0] w_waddr [STAGES];
  logic [DATA_W-1:0] w_wdata [STAGES];

  // A stall on slot k freezes everything younger as well, and a flush at k
  // kills every slot up to k; both reduce to "any bit at or above j".
  for (genvar j = 0; j < STAGES; j++) begin : g_ctl
    assign w_hold[j] = |(stall >> j);
    assign w_kill[j] = |(flush >> j);
  end

  assign w_in_ready = ~w_hold[0] & ~(|flush);
  assign in_ready   = w_in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic              w_src_valid;
    logic              w_src_wen;
    logic [ADDR_W-1:0] w_src_waddr;
    logic [DATA_W-1:0] w_src_wdata;
    logic              w_bubble;

    if (k == 0) begin : g_head
      assign w_src_valid = in_valid & w_in_ready;
      assign w_src_wen   = in_wen;
      assign w_src_waddr = in_waddr;
      assign w_src_wdata = in_wdata;
      assign w_bubble    = 1'b0;
    end else begin : g_body
      assign w_src_valid = w_valid[k-1];
      assign w_src_wen   = w_wen[k-1];
      assign w_src_waddr = w_waddr[k-1];
      assign w_src_wdata = w_wdata[k-1];
      // Source is either frozen (its record stays put) or being killed.
      assign w_bubble    = w_hold[k-1] | w_kill[k-1];
    end

    pipe_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .i_hold   (w_hold[k]),
      .i_bubble (w_bubble),
      .i_kill   (w_kill[k]),
      .i_valid  (w_src_valid),
      .i_wen    (w_src_wen),
      .i_waddr  (w_src_waddr),
      .i_wdata  (w_src_wdata),
      .o_valid  (w_valid[k]),
      .o_wen    (w_wen[k]),
      .o_waddr  (w_waddr[k]),
      .o_wdata  (w_wdata[k])
    );
  end

  assign out_valid = w_valid[STAGES-1];
  assign out_wen   = w_valid[STAGES-1] & w_wen[STAGES-1];
  assign out_waddr = w_waddr[STAGES-1];
  assign out_wdata = w_wdata[STAGES-1];

`ifdef PIPE_FWD_EN
  // Scan oldest to youngest so the youngest matching slot is the last writer.
  always_comb begin
    fwd_data_a = rf_data_a;
    fwd_hit_a  = 1'b0;
    fwd_data_b = rf_data_b;
    fwd_hit_b  = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (w_valid[k] && w_wen[k] && (w_waddr[k] == rd_addr_a) &&
          (rd_addr_a != ADDR_W'(REG_ZERO))) begin
        fwd_data_a = w_wdata[k];
        fwd_hit_a  = 1'b1;
      end
      if (w_valid[k] && w_wen[k] && (w_waddr[k] == rd_addr_b) &&
          (rd_addr_b != ADDR_W'(REG_ZERO))) begin
        fwd_data_b = w_wdata[k];
        fwd_hit_b  = 1'b1;
      end
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{rd_addr_a, rd_addr_b};

  assign fwd_data_a = rf_data_a;
  assign fwd_data_b = rf_data_b;
  assign fwd_hit_a  = 1'b0;
  assign fwd_hit_b  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed self-checking bench for pipe_stage_chain
module tb_pipe_stage_chain;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ST = 4;
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_wen;
  logic [AW-1:0] in_waddr;
  logic [DW-1:0] in_wdata;
  logic [ST-1:0] stall;
  logic [ST-1:0] flush;
  logic          out_valid;
  logic          out_wen;
  logic [AW-1:0] out_waddr;
  logic [DW-1:0] out_wdata;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [DW-1:0] rf_data_a;
  logic [DW-1:0] rf_data_b;
  logic [DW-1:0] fwd_data_a;
  logic [DW-1:0] fwd_data_b;
  logic          fwd_hit_a;
  logic          fwd_hit_b;

  int n_total = 0;
  int n_bad   = 0;

  pipe_stage_chain #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .STAGES (ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wen     (in_wen),
    .in_waddr   (in_waddr),
    .in_wdata   (in_wdata),
    .stall      (stall),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_wen    (out_wen),
    .out_waddr  (out_waddr),
    .out_wdata  (out_wdata),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rf_data_a  (rf_data_a),
    .rf_data_b  (rf_data_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drv(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = v;
    in_wen   = w;
    in_waddr = a;
    in_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_a [7] = '{2, 0, 0, 3, 4, 5, 0};

  initial begin
    rst       = 1'b1;
    stall     = '0;
    flush     = '0;
    drv(1'b0, 1'b0, '0, '0);
    rd_addr_a = 5'd1;
    rf_data_a = 32'h55;
    rd_addr_b = 5'd0;
    rf_data_b = 32'h0;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_wen",   {31'd0, out_wen},   32'd0);
    chk("rst_out_waddr", {27'd0, out_waddr}, 32'd0);
    chk("rst_out_wdata", out_wdata,          32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_fwd_hit_a", {31'd0, fwd_hit_a}, 32'd0);
    chk("rst_fwd_data_a", fwd_data_a,        32'h55);

    // Stream 1..4: accepted at edges 0..3, visible after edges 3..6.
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drv(1'b1, 1'b1, 5'(c + 1), 32'((c + 1) * 17));
      else       drv(1'b0, 1'b0, '0, '0);
      step();
      if (c >= 3 && c <= 6) begin
        chk($sformatf("stream_wen%0d", c),   {31'd0, out_wen},   32'd1);
        chk($sformatf("stream_addr%0d", c),  {27'd0, out_waddr}, 32'(c - 2));
        chk($sformatf("stream_data%0d", c),  out_wdata,          32'((c - 2) * 17));
      end else begin
        chk($sformatf("stream_idle%0d", c),  {31'd0, out_valid}, 32'd0);
      end
    end

    // Stall on slot 1 for two cycles with a full chain.
    for (int i = 1; i <= 4; i++) begin
      drv(1'b1, 1'b1, 5'(i), 32'(i * 17));
      step();
    end
    chk("fill_addr", {27'd0, out_waddr}, 32'd1);
    stall = 4'b0010;
    drv(1'b1, 1'b1, 5'd5, 32'h55);
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int e = 0; e < 7; e++) begin
      if (e == 1) chk("stall_in_ready2", {31'd0, in_ready}, 32'd0);
      if (e == 2) stall = '0;
      if (e == 3) drv(1'b0, 1'b0, '0, '0);
      step();
      if (exp_a[e] != 0) begin
        chk($sformatf("stall_wen%0d", e),  {31'd0, out_wen},   32'd1);
        chk($sformatf("stall_addr%0d", e), {27'd0, out_waddr}, 32'(exp_a[e]));
        chk($sformatf("stall_data%0d", e), out_wdata,          32'(exp_a[e] * 17));
      end else begin
        chk($sformatf("stall_gap%0d", e),  {31'd0, out_valid}, 32'd0);
      end
    end

    // Flush beats stall: flush[2] with stall[0] kills slots 0..2, slot 3 bubbles.
    for (int i = 6; i <= 9; i++) begin
      drv(1'b1, 1'b1, 5'(i), 32'(i * 17));
      step();
    end
    chk("flush_pre_addr", {27'd0, out_waddr}, 32'd6);
    flush = 4'b0001;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 4'b0100;
    stall = 4'b0001;
    drv(1'b1, 1'b1, 5'd10, 32'hAA);
    #1;
    chk("flush_stall_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = '0;
    stall = '0;
    drv(1'b0, 1'b0, '0, '0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("flush_drain%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Forwarding: slot1 {5,AAAA}, slot2 {9,9999}, slot3 {5,BBBB}, slot0 invalid {7}.
    drv(1'b1, 1'b1, 5'd5, 32'hBBBB);
    step();
    drv(1'b1, 1'b1, 5'd9, 32'h9999);
    step();
    drv(1'b1, 1'b1, 5'd5, 32'hAAAA);
    step();
    drv(1'b0, 1'b1, 5'd7, 32'h7777);
    step();
    rd_addr_a = 5'd5;
    rf_data_a = 32'h5151;
    rd_addr_b = 5'd0;
    rf_data_b = 32'h1234;
    #1;
    chk("fwd_out_wdata", out_wdata,          32'hBBBB);
    chk("fwd_a_data",    fwd_data_a,         FWD ? 32'hAAAA : 32'h5151);
    chk("fwd_a_hit",     {31'd0, fwd_hit_a}, {31'd0, FWD});
    chk("fwd_b_zero",    fwd_data_b,         32'h1234);
    chk("fwd_b_zero_hit", {31'd0, fwd_hit_b}, 32'd0);
    rd_addr_b = 5'd9;
    #1;
    chk("fwd_b_data",    fwd_data_b,         FWD ? 32'h9999 : 32'h1234);
    chk("fwd_b_hit",     {31'd0, fwd_hit_b}, {31'd0, FWD});
    rd_addr_a = 5'd7;
    rf_data_a = 32'h0707;
    #1;
    chk("fwd_inv_data",  fwd_data_a,         32'h0707);
    chk("fwd_inv_hit",   {31'd0, fwd_hit_a}, 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("inv_out_wen",   {31'd0, out_wen},   32'd0);
    chk("inv_out_valid", {31'd0, out_valid}, 32'd0);
    chk("inv_fwd_hit",   {31'd0, fwd_hit_a}, 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 11; i <= 14; i++) begin
      drv(1'b1, 1'b1, 5'(i), 32'(i * 17));
      step();
    end
    drv(1'b0, 1'b0, '0, '0);
    chk("pre_rst_wen", {31'd0, out_wen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_wen",   {31'd0, out_wen},   32'd0);
    chk("arst_out_wdata", out_wdata,          32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    drv(1'b1, 1'b1, 5'd15, 32'hFF);
    step();
    drv(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) begin
        chk("post_rst_wen",  {31'd0, out_wen},   32'd1);
        chk("post_rst_addr", {27'd0, out_waddr}, 32'd15);
        chk("post_rst_data", out_wdata,          32'hFF);
      end else begin
        chk($sformatf("post_rst_idle%0d", i), {31'd0, out_valid}, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
